// File: rtl/mesi_isc_broad_queue_if.sv
// rtl/mesi_isc_broad_queue_if.sv - broadcast queue bus between main and broadcast controllers
// Purpose: bundles the push side (main controller), the head/pop side
//   (broadcast controller) and the status/error outputs of the queue.
// Modports:
//   master - controller side: drives broad_wr_i/addr/type/cpu_id and
//            broad_fifo_rd_i; observes ID, head entry, status and errors.
//   slave  - queue side: the mirror image of master.
interface mesi_isc_broad_queue_if #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int FIFO_SIZE_LOG2   = 2
);
  logic                        broad_wr_i;
  logic [ADDR_WIDTH-1:0]       broad_addr_i;
  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i;
  logic [1:0]                  broad_cpu_id_i;
  logic [BROAD_ID_WIDTH-1:0]   broad_id_o;
  logic                        broad_fifo_rd_i;
  logic [ADDR_WIDTH-1:0]       broad_snoop_addr_o;
  logic [BROAD_TYPE_WIDTH-1:0] broad_snoop_type_o;
  logic [1:0]                  broad_snoop_cpu_id_o;
  logic [BROAD_ID_WIDTH-1:0]   broad_snoop_id_o;
  logic                        fifo_status_empty_o;
  logic                        fifo_status_full_o;
  logic [FIFO_SIZE_LOG2:0]     fifo_count_o;
  logic                        overflow_err_o;
  logic                        underflow_err_o;

  modport master (
    output broad_wr_i, broad_addr_i, broad_type_i, broad_cpu_id_i, broad_fifo_rd_i,
    input  broad_id_o, broad_snoop_addr_o, broad_snoop_type_o, broad_snoop_cpu_id_o,
           broad_snoop_id_o, fifo_status_empty_o, fifo_status_full_o, fifo_count_o,
           overflow_err_o, underflow_err_o
  );

  modport slave (
    input  broad_wr_i, broad_addr_i, broad_type_i, broad_cpu_id_i, broad_fifo_rd_i,
    output broad_id_o, broad_snoop_addr_o, broad_snoop_type_o, broad_snoop_cpu_id_o,
           broad_snoop_id_o, fifo_status_empty_o, fifo_status_full_o, fifo_count_o,
           overflow_err_o, underflow_err_o
  );
endinterface

// File: rtl/mesi_isc_broad_queue.sv
// rtl/mesi_isc_broad_queue.sv - ID-tagging broadcast request FIFO
// Purpose: buffers snoop-broadcast requests in order, tags each accepted
//   push with a rolling broadcast ID and presents the head entry to the
//   broadcast controller, which retires it with a one-cycle pop pulse.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bq  - queue bus (slave modport): push request, pop pulse, head entry,
//         next ID, empty/full/count status, sticky overflow/underflow flags
module mesi_isc_broad_queue #(
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int FIFO_SIZE_LOG2   = 2
) (
  input logic                   clk,
  input logic                   rst,
  mesi_isc_broad_queue_if.slave bq
);
  localparam int DEPTH = 1 << FIFO_SIZE_LOG2;
  localparam logic [FIFO_SIZE_LOG2:0] DEPTH_CNT = (FIFO_SIZE_LOG2 + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0]       addr_mem [DEPTH];
  logic [BROAD_TYPE_WIDTH-1:0] type_mem [DEPTH];
  logic [1:0]                  cpu_mem  [DEPTH];
  logic [BROAD_ID_WIDTH-1:0]   id_mem   [DEPTH];

  logic [FIFO_SIZE_LOG2-1:0] rd_ptr;
  logic [FIFO_SIZE_LOG2-1:0] wr_ptr;
  logic [FIFO_SIZE_LOG2:0]   cnt;
  logic [BROAD_ID_WIDTH-1:0] id_cnt;
  logic                      overflow_err;
  logic                      underflow_err;

  logic empty;
  logic full;
  logic push_ok;
  logic pop_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_CNT);

  // A push at full is only taken when the head is retired in the same cycle,
  // so the freed slot is the one being written.
  assign push_ok = bq.broad_wr_i & (~full | bq.broad_fifo_rd_i);
  assign pop_ok  = bq.broad_fifo_rd_i & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      cnt           <= '0;
      id_cnt        <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        type_mem[i] <= '0;
        cpu_mem[i]  <= '0;
        id_mem[i]   <= '0;
      end
    end else begin
      if (push_ok) begin
        addr_mem[wr_ptr] <= bq.broad_addr_i;
        type_mem[wr_ptr] <= bq.broad_type_i;
        cpu_mem[wr_ptr]  <= bq.broad_cpu_id_i;
        id_mem[wr_ptr]   <= id_cnt;
        wr_ptr           <= wr_ptr + 1'b1;
        id_cnt           <= id_cnt + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bq.broad_wr_i & full & ~bq.broad_fifo_rd_i) begin
        overflow_err <= 1'b1;
      end
      if (bq.broad_fifo_rd_i & empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Head is read from storage, never bypassed from the push inputs, so a new
  // entry only appears the cycle after it is written.
  always_comb begin
    bq.broad_snoop_addr_o   = '0;
    bq.broad_snoop_type_o   = '0;
    bq.broad_snoop_cpu_id_o = '0;
    bq.broad_snoop_id_o     = '0;
    if (!empty) begin
      bq.broad_snoop_addr_o   = addr_mem[rd_ptr];
      bq.broad_snoop_type_o   = type_mem[rd_ptr];
      bq.broad_snoop_cpu_id_o = cpu_mem[rd_ptr];
      bq.broad_snoop_id_o     = id_mem[rd_ptr];
    end
  end

  assign bq.broad_id_o          = id_cnt;
  assign bq.fifo_status_empty_o = empty;
  assign bq.fifo_status_full_o  = full;
  assign bq.fifo_count_o        = cnt;
  assign bq.overflow_err_o      = overflow_err;
  assign bq.underflow_err_o     = underflow_err;
endmodule

// File: doc/mesi_isc_broad_queue.md
Name: mesi_isc_broad_queue

Overview:
- Broadcast request queue between the main coherence controller and the broadcast controller.
- Accepts snoop-broadcast requests from the main controller and tags each one with a rolling broadcast ID.
- Buffers the requests in order and presents the head entry, plus empty/full status, to the broadcast controller.
- The broadcast controller retires the head entry with a one-cycle read pulse when all snoops and the initiator enable have completed.

Parameters:
ADDR_WIDTH, 32, width of the cache-line address carried with each broadcast
BROAD_TYPE_WIDTH, 2, width of the broadcast type field (RD/WR encodings from mesi_isc_define)
BROAD_ID_WIDTH, 5, width of the broadcast ID tag
FIFO_SIZE_LOG2, 2, log2 of queue depth (default depth 4 entries)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (asserted at 0)
broad_wr_i  input  1  push request from main controller
broad_addr_i  input  ADDR_WIDTH  line address of the request
broad_type_i  input  BROAD_TYPE_WIDTH  broadcast type
broad_cpu_id_i  input  2  initiator CPU ID
broad_id_o  output  BROAD_ID_WIDTH  ID that the next accepted push will receive
broad_fifo_rd_i  input  1  pop pulse from broadcast controller
broad_snoop_addr_o  output  ADDR_WIDTH  head entry address
broad_snoop_type_o  output  BROAD_TYPE_WIDTH  head entry type
broad_snoop_cpu_id_o  output  2  head entry initiator
broad_snoop_id_o  output  BROAD_ID_WIDTH  head entry ID
fifo_status_empty_o  output  1  queue holds zero entries
fifo_status_full_o  output  1  queue holds 2^FIFO_SIZE_LOG2 entries
fifo_count_o  output  FIFO_SIZE_LOG2+1  current occupancy
overflow_err_o  output  1  sticky: push dropped while full
underflow_err_o  output  1  sticky: pop seen while empty

Behaviour:
- Storage: circular buffer of DEPTH=2^FIFO_SIZE_LOG2 entries {addr, type, cpu_id, id}.
  - Pointers rd_ptr and wr_ptr are FIFO_SIZE_LOG2 bits and wrap modulo DEPTH.
  - Occupancy counter cnt is FIFO_SIZE_LOG2+1 bits.
- Reset (rst=0, async):
  - Pointers, cnt, ID counter, both error flags and all entries clear to 0.
  - Outputs: empty_o=1, full_o=0, count_o=0, broad_id_o=0, all head outputs=0, error flags=0.
  - Reset mid-operation discards all queued entries immediately; no pending pop survives.
- Push accept condition: push_ok = broad_wr_i & (~full | broad_fifo_rd_i).
  - Push at full is accepted only when a pop occurs in the same cycle.
  - On push_ok: entry {broad_addr_i, broad_type_i, broad_cpu_id_i, id_cnt} is written at wr_ptr; wr_ptr++; id_cnt++.
- Pop accept condition: pop_ok = broad_fifo_rd_i & ~empty.
  - On pop_ok: rd_ptr++.
- Occupancy update: cnt += push_ok - pop_ok.
  - Simultaneous push_ok and pop_ok leaves cnt unchanged.
- Push while empty with a pop in the same cycle: the pop is ignored (empty) and raises underflow_err_o; the push is accepted.
- Status flags are combinational from cnt: empty_o=(cnt==0), full_o=(cnt==DEPTH), count_o=cnt.
- Head outputs:
  - Combinational from entry[rd_ptr] when ~empty; forced to 0 when empty.
  - No fall-through: a push into an empty queue becomes visible on the head outputs, with empty_o=0, the cycle after the push edge.
  - Head is stable while not popped; pushes never alter entry[rd_ptr] when cnt>0.
  - The broadcast controller relies on this across its multi-cycle broadcast.
- ID counter: broad_id_o=id_cnt. It increments only on push_ok, wraps 2^BROAD_ID_WIDTH-1 -> 0, and is unaffected by pops.
- Error flags:
  - overflow_err_o sets on broad_wr_i & full & ~broad_fifo_rd_i; the push is dropped and id_cnt is not incremented.
  - underflow_err_o sets on broad_fifo_rd_i & empty; no state changes.
  - Both flags clear only on reset.
- Latency: push to head visible = 1 cycle (empty queue); pop to next entry visible = 1 cycle.
- Throughput: one push and one pop per cycle.

Test Plan:
- Reset then push {addr=0x1000, type=WR, cpu=2} -> next cycle empty_o=0, count_o=1, head addr=0x1000, cpu=2, id=0; broad_id_o=1.
- Push 4 entries (ids 0..3), then a 5th push without pop -> full_o=1, count_o=4, 5th dropped, overflow_err_o=1, broad_id_o stays 4; pops return ids 0,1,2,3 in order, then empty_o=1.
- At full, assert broad_wr_i and broad_fifo_rd_i together -> count_o stays 4, no overflow, head advances to id 1, new entry gets id 4 at tail.
- Pop pulse with queue empty -> underflow_err_o=1, count_o=0, pointers unchanged; a later push/pop pair still yields correct head.
- 33 push/pop pairs -> IDs 0..31 then 0; pointers wrap every 4; head fields match pushed data each time.
- With 3 entries queued, drive rst=0 asynchronously mid-cycle -> outputs clear immediately: empty_o=1, count_o=0, broad_id_o=0; after release, first push gets id 0.
